fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 The parameter COL_BIT_WIDTH SHALL default to 32 and set the data word width.
REQ-002 The parameter ROWS SHALL default to 8 and set the storage depth; it is a power of two and at least 2.
REQ-003 The parameter ROW_ADDR_WIDTH SHALL default to $clog2(ROWS) and set the row index width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 w_req  input  1  write request.
REQ-008 w_data  input  COL_BIT_WIDTH  write data, sampled with w_req.
REQ-009 r_req  input  1  read request (pop).
REQ-010 r_data  output  COL_BIT_WIDTH  head-of-queue data.
REQ-011 write_ptr  output  ROW_ADDR_WIDTH+1  tail pointer; MSB is the wrap bit.
REQ-012 read_ptr  output  ROW_ADDR_WIDTH+1  head pointer; MSB is the wrap bit.
REQ-013 w_stall  output  1  full; write not accepted.
REQ-014 r_stall  output  1  empty; read not accepted.

Function
REQ-015 Empty SHALL be write_ptr == read_ptr; full SHALL be equal low ROW_ADDR_WIDTH bits with differing MSBs.
REQ-016 w_stall SHALL equal full and r_stall SHALL equal empty, both combinational from registered pointers only.
REQ-017 A write SHALL occur at a rising clk edge iff w_req && !w_stall: mem[write_ptr low bits] <= w_data, write_ptr increments by 1.
REQ-018 A read SHALL occur at a rising clk edge iff r_req && !r_stall: read_ptr increments by 1.
REQ-019 r_data SHALL be first-word-fall-through: combinationally mem[read_ptr low bits] when not empty, all-zero when empty.
REQ-020 Pointers SHALL wrap modulo 2*ROWS, toggling the MSB each lap.
REQ-021 With simultaneous requests, write and read SHALL each be qualified independently by the current-cycle stalls: when full, only the read occurs; when empty, only the write occurs; otherwise both occur and occupancy is unchanged.
REQ-022 A stalled request SHALL be dropped with no state change; the requester re-presents it.
REQ-023 Storage SHALL not be reset; only pointers are reset.

Reset
REQ-024 While reset is high, write_ptr and read_ptr SHALL be 0 immediately, giving w_stall=0, r_stall=1 and r_data=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries; no access occurs on an edge while reset is high.

Configuration
REQ-026 With FIFO_COUNT_EN defined, an extra output count [ROW_ADDR_WIDTH:0] SHALL equal write_ptr - read_ptr (modulo 2*ROWS, range 0..ROWS); without it, the port and its logic SHALL be absent.

Structure
REQ-027 The package fifo_pkg SHALL hold the default COL_BIT_WIDTH and ROWS constants and a pointer-width helper function.
REQ-028 The storage array SHALL be one sub-module, fifo_mem: a synchronous-write, asynchronous-read register file. Pointer and flag logic SHALL stay in fifo.

Verification
REQ-029 Reset scenario: reset pulse -> write_ptr=0, read_ptr=0, r_stall=1, w_stall=0, r_data=0.
REQ-030 Basic order scenario: write 14, 18, 16 -> write_ptr=3 and r_data=14; read -> r_data=18; then simultaneous read plus write of 8 -> r_data=16 and occupancy stays 2.
REQ-031 Full scenario: from empty, write 20..27 -> w_stall=1 and write_ptr=4'b1000; a ninth write of 99 is dropped and write_ptr is unchanged.
REQ-032 Full simultaneous scenario: when full, read and write of 50 together -> read accepted, write dropped, count=7, w_stall=0.
REQ-033 Empty simultaneous scenario: when empty, read and write of 9 together -> read ignored, write accepted; next cycle r_data=9 and r_stall=0.
REQ-034 Wrap and mid-operation reset scenario: 12 writes interleaved with 12 reads -> pointers wrap to 4'b1100 with data order preserved; asserting reset with 3 entries queued -> pointers=0 and r_stall=1 immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the fifo block.
package fifo_pkg;

  localparam int COL_BIT_WIDTH_DEF = 32;
  localparam int ROWS_DEF          = 8;

  // Pointers carry one extra wrap bit above the row index.
  function automatic int ptr_width(input int row_addr_width);
    return row_addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-file storage for fifo: synchronous write, asynchronous read.
// Rows are intentionally not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int W    = COL_BIT_WIDTH_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [ROWS-1:0][W-1:0] mem;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    always_ff @(posedge clk) begin
      if (we && (waddr == AW'(i))) mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// Optional occupancy output `count` is enabled by defining FIFO_COUNT_EN.
module fifo
  import fifo_pkg::*;
#(
  parameter int COL_BIT_WIDTH  = COL_BIT_WIDTH_DEF,
  parameter int ROWS           = ROWS_DEF,
  parameter int ROW_ADDR_WIDTH = $clog2(ROWS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_req,
  input  logic [COL_BIT_WIDTH-1:0]  w_data,
  input  logic                      r_req,
  output logic [COL_BIT_WIDTH-1:0]  r_data,
  output logic [ROW_ADDR_WIDTH:0]   write_ptr,
  output logic [ROW_ADDR_WIDTH:0]   read_ptr,
  output logic                      w_stall,
  output logic                      r_stall
`ifdef FIFO_COUNT_EN
  ,
  output logic [ROW_ADDR_WIDTH:0]   count
`endif
);

  localparam int PTR_W = ptr_width(ROW_ADDR_WIDTH);

  logic                     empty, full;
  logic                     wr_en, rd_en;
  logic [COL_BIT_WIDTH-1:0] mem_rdata;

  // Flags come only from registered pointers, so stalls never depend on requests.
  assign empty = (write_ptr == read_ptr);
  assign full  = (write_ptr[ROW_ADDR_WIDTH-1:0] == read_ptr[ROW_ADDR_WIDTH-1:0]) &&
                 (write_ptr[ROW_ADDR_WIDTH] != read_ptr[ROW_ADDR_WIDTH]);

  assign w_stall = full;
  assign r_stall = empty;

  assign wr_en = w_req && !full;
  assign rd_en = r_req && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
    end else begin
      if (wr_en) write_ptr <= write_ptr + PTR_W'(1);
      if (rd_en) read_ptr  <= read_ptr + PTR_W'(1);
    end
  end

  // Gate the storage write with reset so no row changes while reset is held.
  fifo_mem #(
    .W    (COL_BIT_WIDTH),
    .ROWS (ROWS),
    .AW   (ROW_ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en && !reset),
    .waddr (write_ptr[ROW_ADDR_WIDTH-1:0]),
    .wdata (w_data),
    .raddr (read_ptr[ROW_ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  assign r_data = empty ? '0 : mem_rdata;

`ifdef FIFO_COUNT_EN
  assign count = write_ptr - read_ptr;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: stimulus pushes expected read data into a queue,
// a negedge monitor pops and compares on every accepted read.
module tb_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_req;
  logic [31:0] w_data;
  logic        r_req;
  logic [31:0] r_data;
  logic [3:0]  write_ptr;
  logic [3:0]  read_ptr;
  logic        w_stall;
  logic        r_stall;
`ifdef FIFO_COUNT_EN
  logic [3:0]  count;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fifo dut (
    .clk       (clk),
    .reset     (reset),
    .w_req     (w_req),
    .w_data    (w_data),
    .r_req     (r_req),
    .r_data    (r_data),
    .write_ptr (write_ptr),
    .read_ptr  (read_ptr),
    .w_stall   (w_stall),
    .r_stall   (r_stall)
`ifdef FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: a read is accepted on the coming edge when r_req && !r_stall.
  always @(negedge clk) begin
    if (!reset && r_req && !r_stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_underflow: got %0d expected none", r_data);
      end else begin
        chk("mon_rdata", r_data, exp_q.pop_front());
      end
    end
  end

  task automatic cycle(input logic w, input logic [31:0] d, input logic r);
    w_req  = w;
    w_data = d;
    r_req  = r;
    @(posedge clk);
    #1;
    w_req  = 1'b0;
    r_req  = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] d);
    exp_q.push_back(d);
    cycle(1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [3:0] occ();
    return write_ptr - read_ptr;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; w_req = 1'b0; r_req = 1'b0; w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wptr",   32'(write_ptr), 0);
    chk("rst_rptr",   32'(read_ptr),  0);
    chk("rst_rstall", 32'(r_stall),   1);
    chk("rst_wstall", 32'(w_stall),   0);
    chk("rst_rdata",  r_data,         0);
    reset = 1'b0;

    // Basic ordering
    push_wr(14); push_wr(18); push_wr(16);
    chk("ord_wptr",  32'(write_ptr), 3);
    chk("ord_head",  r_data,         14);
    cycle(1'b0, 0, 1'b1);
    chk("ord_head2", r_data,         18);
    exp_q.push_back(8);
    cycle(1'b1, 8, 1'b1);
    chk("ord_head3", r_data,         16);
    chk("ord_occ",   32'(occ()),     2);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b1);
    chk("ord_empty", 32'(r_stall),   1);

    // Fill from empty
    do_reset();
    for (int i = 20; i <= 27; i++) push_wr(32'(i));
    chk("full_wstall", 32'(w_stall),   1);
    chk("full_wptr",   32'(write_ptr), 8);
    cycle(1'b1, 99, 1'b0);
    chk("full_drop_wptr", 32'(write_ptr), 8);
    chk("full_drop_head", r_data,         20);

    // Simultaneous read+write while full: only the read happens
    cycle(1'b1, 50, 1'b1);
    chk("fsim_occ",    32'(occ()),     7);
    chk("fsim_wstall", 32'(w_stall),   0);
    chk("fsim_wptr",   32'(write_ptr), 8);
`ifdef FIFO_COUNT_EN
    chk("fsim_count",  32'(count),     7);
`endif
    repeat (7) cycle(1'b0, 0, 1'b1);
    chk("fsim_drained", 32'(r_stall), 1);

    // Simultaneous read+write while empty: only the write happens
    exp_q.push_back(9);
    cycle(1'b1, 9, 1'b1);
    chk("esim_rdata",  r_data,       9);
    chk("esim_rstall", 32'(r_stall), 0);
    chk("esim_rptr",   32'(read_ptr), 8);
    cycle(1'b0, 0, 1'b1);

    // Wrap: 12 interleaved write/read pairs from zero
    do_reset();
    for (int i = 0; i < 12; i++) begin
      push_wr(32'(100 + i));
      cycle(1'b0, 0, 1'b1);
    end
    chk("wrap_wptr", 32'(write_ptr), 12);
    chk("wrap_rptr", 32'(read_ptr),  12);

    // Reset with entries queued
    push_wr(1); push_wr(2); push_wr(3);
    chk("mid_occ", 32'(occ()), 3);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_wptr",   32'(write_ptr), 0);
    chk("mid_rptr",   32'(read_ptr),  0);
    chk("mid_rstall", 32'(r_stall),   1);
    chk("mid_rdata",  r_data,         0);
    w_req = 1'b1; w_data = 77;
    @(posedge clk);
    #1;
    chk("mid_hold_wptr", 32'(write_ptr), 0);
    w_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_after_rstall", 32'(r_stall), 1);

    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
